// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation
// encodings, FSM states and small opcode decode helpers.
package mips_pkg;

  // Operation encodings carried on i_op.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // Sequencer states: accept, iterate, correct signs and write HI/LO.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // MULT and DIV treat their operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // Anything that is not a multiply is a divide.
  function automatic logic op_is_div(input logic [1:0] op);
    return !((op == MD_MULT) || (op == MD_MULTU));
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage side of the multiply/divide unit: operation request, HI/LO
// moves and the status/stall outputs. The EX stage is the master.
interface muldiv_sequencer_if #(
  parameter int NB_DATA = 32
);
  logic               i_halt;
  logic               i_flush;
  logic               i_start;
  logic [1:0]         i_op;
  logic [NB_DATA-1:0] i_datoA;
  logic [NB_DATA-1:0] i_datoB;
  logic               i_rd_hilo;
  logic               i_hi_we;
  logic               i_lo_we;
  logic [NB_DATA-1:0] i_wdata;
  logic [NB_DATA-1:0] o_hi;
  logic [NB_DATA-1:0] o_lo;
  logic               o_busy;
  logic               o_stall;
  logic               o_done;

  modport master (
    output i_halt, i_flush, i_start, i_op, i_datoA, i_datoB,
           i_rd_hilo, i_hi_we, i_lo_we, i_wdata,
    input  o_hi, o_lo, o_busy, o_stall, o_done
  );

  modport slave (
    input  i_halt, i_flush, i_start, i_op, i_datoA, i_datoB,
           i_rd_hilo, i_hi_we, i_lo_we, i_wdata,
    output o_hi, o_lo, o_busy, o_stall, o_done
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath, purely combinational.
// Multiply: acc = {partial product, remaining multiplier bits}; add the
//   multiplicand into the upper half when the multiplier LSB is set, then
//   shift right (the carry enters the top bit).
// Divide: acc = {partial remainder, remaining dividend bits}; shift left
//   one bit into the remainder and subtract the divisor if it fits.
//   The quotient bit is returned separately; acc_next[0] is left at 0.
module muldiv_step #(
  parameter int NB_DATA = 32
) (
  input  logic                 mode,      // 1 = divide, 0 = multiply
  input  logic [2*NB_DATA-1:0] acc,
  input  logic [NB_DATA-1:0]   opnd,
  output logic [2*NB_DATA-1:0] acc_next,
  output logic                 q_bit
);

  logic [NB_DATA:0]   mul_sum;
  logic [NB_DATA:0]   rem_sh;
  logic [NB_DATA-1:0] rem_sub;

  // Single shift-add or restoring shift-subtract iteration.
  always_comb begin
    mul_sum  = {1'b0, acc[2*NB_DATA-1:NB_DATA]}
             + {1'b0, (acc[0] ? opnd : {NB_DATA{1'b0}})};
    rem_sh   = {acc[2*NB_DATA-1:NB_DATA], acc[NB_DATA-1]};
    // The true difference is below the divisor, so N bits are enough.
    rem_sub  = rem_sh[NB_DATA-1:0] - opnd;
    acc_next = '0;
    q_bit    = 1'b0;
    if (mode) begin
      if (rem_sh >= {1'b0, opnd}) begin
        acc_next = {rem_sub, acc[NB_DATA-2:0], 1'b0};
        q_bit    = 1'b1;
      end else begin
        acc_next = {rem_sh[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[NB_DATA-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller for the EX stage. Owns HI/LO,
// runs one datapath iteration per cycle on operand magnitudes, and applies
// sign correction when writing the result. NB_CNT must cover NB_DATA
// iterations (2**NB_CNT >= NB_DATA).
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = 5
) (
  input  logic clk,
  input  logic i_rst_n,
  muldiv_sequencer_if.slave bus
);

  md_state_e              state_reg;
  logic [NB_CNT-1:0]      cnt_reg;
  logic [2*NB_DATA-1:0]   acc_reg;
  logic [NB_DATA-1:0]     opnd_reg;
  logic [NB_DATA-1:0]     hi_reg;
  logic [NB_DATA-1:0]     lo_reg;
  logic                   is_div_reg;
  logic                   neg_lo_reg;   // product sign (mult) or quotient sign (div)
  logic                   neg_hi_reg;   // remainder sign (div only)
  logic                   done_reg;

  logic                   sgn_op;
  logic                   div_op;
  logic                   sign_a;
  logic                   sign_b;
  logic [NB_DATA-1:0]     mag_a;
  logic [NB_DATA-1:0]     mag_b;
  logic [2*NB_DATA-1:0]   step_acc;
  logic                   step_q;
  logic [2*NB_DATA-1:0]   prod_fix;
  logic [NB_DATA-1:0]     quo_fix;
  logic [NB_DATA-1:0]     rem_fix;
  logic                   busy;

  // Operand decode for the start edge: signs and magnitudes.
  always_comb begin
    sgn_op = op_is_signed(bus.i_op);
    div_op = op_is_div(bus.i_op);
    sign_a = sgn_op & bus.i_datoA[NB_DATA-1];
    sign_b = sgn_op & bus.i_datoB[NB_DATA-1];
    mag_a  = sign_a ? -bus.i_datoA : bus.i_datoA;
    mag_b  = sign_b ? -bus.i_datoB : bus.i_datoB;
  end

  // Sign-corrected results presented to HI/LO in the FIX state.
  always_comb begin
    prod_fix = neg_lo_reg ? -acc_reg : acc_reg;
    quo_fix  = neg_lo_reg ? -acc_reg[NB_DATA-1:0] : acc_reg[NB_DATA-1:0];
    rem_fix  = neg_hi_reg ? -acc_reg[2*NB_DATA-1:NB_DATA]
                          : acc_reg[2*NB_DATA-1:NB_DATA];
  end

  muldiv_step #(
    .NB_DATA (NB_DATA)
  ) u_step (
    .mode     (is_div_reg),
    .acc      (acc_reg),
    .opnd     (opnd_reg),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Sequencer FSM, iteration counter, datapath registers and HI/LO.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= MD_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else if (!bus.i_halt) begin
      done_reg <= 1'b0;
      case (state_reg)
        MD_IDLE: begin
          if (bus.i_start && !bus.i_flush) begin
            opnd_reg   <= mag_b;
            is_div_reg <= div_op;
            cnt_reg    <= '0;
            if (div_op && (bus.i_datoB == '0)) begin
              // Divide by zero: preload the fixed result, no iterations.
              acc_reg    <= {bus.i_datoA, {NB_DATA{1'b1}}};
              neg_lo_reg <= 1'b0;
              neg_hi_reg <= 1'b0;
              state_reg  <= MD_FIX;
            end else begin
              acc_reg    <= {{NB_DATA{1'b0}}, mag_a};
              neg_lo_reg <= sign_a ^ sign_b;
              neg_hi_reg <= sign_a;
              state_reg  <= MD_RUN;
            end
          end else if (!bus.i_start) begin
            // A start that coincides with MTHI/MTLO takes priority.
            if (bus.i_hi_we) hi_reg <= bus.i_wdata;
            if (bus.i_lo_we) lo_reg <= bus.i_wdata;
          end
        end
        MD_RUN: begin
          if (bus.i_flush) begin
            state_reg <= MD_IDLE;
          end else begin
            acc_reg <= step_acc | {{(2*NB_DATA-1){1'b0}}, step_q};
            if (cnt_reg == NB_CNT'(NB_DATA - 1)) begin
              state_reg <= MD_FIX;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        MD_FIX: begin
          if (!bus.i_flush) begin
            if (is_div_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end else begin
              hi_reg <= prod_fix[2*NB_DATA-1:NB_DATA];
              lo_reg <= prod_fix[NB_DATA-1:0];
            end
            done_reg <= 1'b1;
          end
          state_reg <= MD_IDLE;
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

  assign busy         = (state_reg == MD_RUN) || (state_reg == MD_FIX);
  assign bus.o_busy   = busy;
  assign bus.o_stall  = busy & (bus.i_start | bus.i_rd_hilo | bus.i_hi_we | bus.i_lo_we);
  assign bus.o_hi     = hi_reg;
  assign bus.o_lo     = lo_reg;
  assign bus.o_done   = done_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer. Expected HI/LO come from plain
// 64-bit arithmetic on the operands; expected latency from the edge counts
// of the operation type. Inputs change and outputs are sampled on negedge.
module tb_muldiv_sequencer;
  import mips_pkg::*;

  localparam int N = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.NB_DATA(N)) bus ();

  muldiv_sequencer #(
    .NB_DATA (N),
    .NB_CNT  (5)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [N-1:0] ref_hi = '0;
  logic [N-1:0] ref_lo = '0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition of each op.
  function automatic void ref_op(input logic [1:0] op, input logic [N-1:0] a,
                                 input logic [N-1:0] b,
                                 output logic [N-1:0] hi, output logic [N-1:0] lo);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    hi = '0;
    lo = '0;
    if (op == MD_MULT) begin
      t = 64'(sa * sb);
      hi = t[63:32]; lo = t[31:0];
    end else if (op == MD_MULTU) begin
      t = ua * ub;
      hi = t[63:32]; lo = t[31:0];
    end else if (b == '0) begin
      lo = '1; hi = a;
    end else if (op == MD_DIV) begin
      sq = sa / sb; sr = sa % sb;
      t = 64'(sq); lo = t[31:0];
      t = 64'(sr); hi = t[31:0];
    end else begin
      t = ua / ub; lo = t[31:0];
      t = ua % ub; hi = t[31:0];
    end
  endfunction

  task automatic idle_inputs();
    bus.i_halt = 0; bus.i_flush = 0; bus.i_start = 0; bus.i_op = 2'b00;
    bus.i_datoA = '0; bus.i_datoB = '0; bus.i_rd_hilo = 0;
    bus.i_hi_we = 0; bus.i_lo_we = 0; bus.i_wdata = '0;
  endtask

  // Issue one op, optionally halt for halt_len edges starting halt_at
  // edges after the start edge, then check latency and result.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input int halt_at, input int halt_len);
    logic [N-1:0] eh, el;
    int exp_lat, lat;
    ref_op(op, a, b, eh, el);
    exp_lat = (op_is_div(op) && b == '0) ? 1 : N + 1;
    bus.i_start = 1; bus.i_op = op; bus.i_datoA = a; bus.i_datoB = b;
    @(negedge clk);
    bus.i_start = 0;
    lat = 0;
    while (!bus.o_done && lat < 200) begin
      if (halt_len > 0 && lat == halt_at) bus.i_halt = 1;
      if (halt_len > 0 && lat == halt_at + halt_len) bus.i_halt = 0;
      if (lat == 2 && exp_lat > 2) begin
        chk({tag, "_hold_hi"}, bus.o_hi, ref_hi);
        chk({tag, "_hold_lo"}, bus.o_lo, ref_lo);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
      end
      @(negedge clk);
      lat++;
    end
    bus.i_halt = 0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat + halt_len));
    chk({tag, "_hi"}, bus.o_hi, eh);
    chk({tag, "_lo"}, bus.o_lo, el);
    chk({tag, "_busy_end"}, 32'(bus.o_busy), 32'd0);
    ref_hi = eh;
    ref_lo = el;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus.o_done), 32'd0);
    $display("op %s op=%0d A=%h B=%h -> HI=%h LO=%h lat=%0d", tag, op, a, b, bus.o_hi, bus.o_lo, lat);
  endtask

  initial begin
    int t;
    logic [1:0] rop;
    logic [N-1:0] ra, rb;
    idle_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hi", bus.o_hi, '0);
    chk("rst_lo", bus.o_lo, '0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    bus.i_rd_hilo = 1;
    #1 chk("rst_stall", 32'(bus.o_stall), 32'd0);
    bus.i_rd_hilo = 0;
    rst_n = 1;
    @(negedge clk);

    // Directed arithmetic cases, including divide-by-zero and overflow
    do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op("mult_neg",  MD_MULT,  32'hFFFF_FFF9, 32'd3, 0, 0);
    do_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0);
    do_op("divu_zero", MD_DIVU,  32'd100, 32'd0, 0, 0);
    do_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

    // MFLO right behind MULT: stalled until the op retires
    bus.i_start = 1; bus.i_op = MD_MULT; bus.i_datoA = 32'd6; bus.i_datoB = 32'd7;
    @(negedge clk);
    bus.i_start = 0; bus.i_rd_hilo = 1;
    t = 0;
    while (bus.o_busy && t < 100) begin
      chk("mflo_stall", 32'(bus.o_stall), 32'd1);
      @(negedge clk);
      t++;
    end
    chk("mflo_wait", 32'(t), 32'd33);
    chk("mflo_unstall", 32'(bus.o_stall), 32'd0);
    chk("mflo_lo", bus.o_lo, 32'd42);
    $display("op mflo_after_mult stalls=%0d LO=%h", t, bus.o_lo);
    bus.i_rd_hilo = 0;
    ref_hi = '0; ref_lo = 32'd42;
    @(negedge clk);

    // MTHI and MTLO together in IDLE
    bus.i_hi_we = 1; bus.i_lo_we = 1; bus.i_wdata = 32'hA5A5_0001;
    @(negedge clk);
    bus.i_hi_we = 0; bus.i_lo_we = 0;
    chk("mt_both_hi", bus.o_hi, 32'hA5A5_0001);
    chk("mt_both_lo", bus.o_lo, 32'hA5A5_0001);
    ref_hi = 32'hA5A5_0001; ref_lo = 32'hA5A5_0001;
    $display("op mt_both HI=%h LO=%h", bus.o_hi, bus.o_lo);

    // MTHI then DIVU flushed mid-RUN: HI/LO untouched, no done
    bus.i_hi_we = 1; bus.i_wdata = 32'h0000_1234;
    @(negedge clk);
    bus.i_hi_we = 0;
    chk("mthi", bus.o_hi, 32'h0000_1234);
    ref_hi = 32'h0000_1234;
    bus.i_start = 1; bus.i_op = MD_DIVU; bus.i_datoA = 32'd9; bus.i_datoB = 32'd4;
    @(negedge clk);
    bus.i_start = 0;
    repeat (10) @(negedge clk);
    bus.i_flush = 1;
    @(negedge clk);
    bus.i_flush = 0;
    chk("flush_busy", 32'(bus.o_busy), 32'd0);
    chk("flush_hi", bus.o_hi, 32'h0000_1234);
    chk("flush_lo", bus.o_lo, ref_lo);
    t = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done) t++;
    end
    chk("flush_no_done", 32'(t), 32'd0);
    $display("op divu_flushed HI=%h LO=%h", bus.o_hi, bus.o_lo);
    do_op("divu_rerun", MD_DIVU, 32'd9, 32'd4, 0, 0);

    // Start together with flush in IDLE is dropped
    bus.i_start = 1; bus.i_flush = 1; bus.i_op = MD_MULTU; bus.i_datoA = 32'd3; bus.i_datoB = 32'd3;
    @(negedge clk);
    bus.i_start = 0; bus.i_flush = 0;
    chk("start_flush_busy", 32'(bus.o_busy), 32'd0);
    $display("op start_with_flush busy=%0d", bus.o_busy);

    // MTHI/MTLO while busy: stalled and not written
    bus.i_start = 1; bus.i_op = MD_MULTU; bus.i_datoA = 32'd3; bus.i_datoB = 32'd5;
    @(negedge clk);
    bus.i_start = 0; bus.i_hi_we = 1; bus.i_lo_we = 1; bus.i_wdata = 32'hDEAD_BEEF;
    #1 chk("mt_busy_stall", 32'(bus.o_stall), 32'd1);
    repeat (3) @(negedge clk);
    bus.i_hi_we = 0; bus.i_lo_we = 0;
    t = 0;
    while (!bus.o_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mt_busy_hi", bus.o_hi, 32'd0);
    chk("mt_busy_lo", bus.o_lo, 32'd15);
    ref_hi = '0; ref_lo = 32'd15;
    $display("op mt_while_busy HI=%h LO=%h", bus.o_hi, bus.o_lo);
    @(negedge clk);

    // Halt for 5 edges mid-RUN stretches latency by 5
    do_op("mult_halt", MD_MULT, 32'h1234_5678, 32'hFEDC_BA98, 7, 5);

    // Random operations against the arithmetic model
    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = $urandom; end
        default: rb = $urandom;
      endcase
      do_op("rand", rop, ra, rb, 0, 0);
    end

    // Async reset mid-RUN discards the op and clears HI/LO
    bus.i_start = 1; bus.i_op = MD_DIV; bus.i_datoA = 32'd1000; bus.i_datoB = 32'd7;
    @(negedge clk);
    bus.i_start = 0;
    repeat (10) @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_busy", 32'(bus.o_busy), 32'd0);
    chk("arst_hi", bus.o_hi, '0);
    chk("arst_lo", bus.o_lo, '0);
    $display("op reset_mid_run busy=%0d HI=%h LO=%h", bus.o_busy, bus.o_hi, bus.o_lo);
    @(negedge clk);
    rst_n = 1;
    ref_hi = '0; ref_lo = '0;
    @(negedge clk);
    do_op("after_reset", MD_DIV, 32'd1000, 32'hFFFF_FFF9, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
